spi_master_par: RTL and testbench
=================================

SPI_MASTER_PAR -- requirements
Module: spi_master_par

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, setting the transfer word width in bits (minimum 2).
REQ-002 The block SHALL have a parameter SEL_W, default 2, setting the slave-select address width; NUM_SS = 2**SEL_W.
REQ-003 clk  input  1  single system clock; all logic updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 en  input  1  transfer start request, sampled only in IDLE.
REQ-006 clk_sel  input  3  SCK divider; half-period H = 2**clk_sel clk cycles.
REQ-007 mode  input  2  {CPOL, CPHA}, SPI modes 0 to 3.
REQ-008 lsb_first  input  1  1 = LSB shifted first, 0 = MSB first.
REQ-009 ss_sel  input  SEL_W  index of the slave to address.
REQ-010 data_in  input  DATA_W  word to transmit.
REQ-011 miso  input  1  serial data from the slave.
REQ-012 data_out  output  DATA_W  last completed received word.
REQ-013 sck  output  1  SPI serial clock.
REQ-014 mosi  output  1  serial data to the slave.
REQ-015 ss  output  NUM_SS  active-low slave selects, one-hot-low during a transfer.
REQ-016 busy  output  1  high while a transfer is in progress.
REQ-017 irq  output  1  one-cycle done pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, XFER, HOLD and DONE.
REQ-019 IDLE with en=1: on the next edge, latch data_in, clk_sel, mode, lsb_first and ss_sel; set busy=1; drive ss[ss_sel]=0; enter SETUP.
REQ-020 Input changes after the latch SHALL have no effect until the next transfer.
REQ-021 en in any state other than IDLE SHALL be ignored; requests are not queued.
REQ-022 SETUP SHALL last H cycles with sck=CPOL and mosi already carrying the first bit.
REQ-023 XFER SHALL produce 2*DATA_W SCK edges, one every H cycles; edge 1 is the leading edge (away from CPOL).
REQ-024 CPHA=0: miso is sampled on leading edges; mosi advances on trailing edges except the last.
REQ-025 CPHA=1: mosi advances on leading edges except the first; miso is sampled on trailing edges.
REQ-026 Bit order follows the latched lsb_first for both the transmit and receive words.
REQ-027 HOLD SHALL last H cycles with sck=CPOL and ss still asserted.
REQ-028 DONE SHALL last exactly one cycle: ss all ones, busy=0, irq=1, data_out updated to the received word; next state IDLE.
REQ-029 busy SHALL be high for exactly (2*DATA_W+2)*H consecutive cycles per transfer.
REQ-030 With en held high, the next transfer SHALL latch on the edge after the DONE cycle.
REQ-031 In IDLE, sck SHALL equal the registered mode[1] and mosi SHALL be 0.
REQ-032 data_out SHALL change only in DONE or on reset.
REQ-033 The divider counter SHALL wrap at H-1 with no drift across edges; clk_sel=0 gives sck = clk/2.

Reset
REQ-034 While rst=0 at a clk edge, outputs SHALL become: state=IDLE, sck=0, mosi=0, ss=all ones, busy=0, irq=0, data_out=0; shift registers, counters and latched configuration SHALL be cleared to 0.
REQ-035 Reset mid-transfer SHALL abort the transfer at the next edge, with no irq and ss deasserted.
REQ-036 The first en SHALL be honoured on the first edge with rst=1.

Verification
REQ-037 Mode 0, MSB first, clk_sel=0, ss_sel=0, data_in=0xA5, mosi looped to miso -> data_out=0xA5; busy high 18 cycles; one irq; ss=4'b1110 during the transfer.
REQ-038 Mode 3, lsb_first=1, clk_sel=2, ss_sel=2, slave model returns 0x3C -> data_out=0x3C; slave captures data_in; ss=4'b1011; sck idle high; busy high 72 cycles.
REQ-039 en pulsed again mid-XFER with a different data_in -> ignored; only one irq; original word transmitted.
REQ-040 rst=0 after the 3rd leading edge -> next cycle ss=4'hF, busy=0, irq=0, data_out=0; a following transfer of 0x5A completes correctly.
REQ-041 en held high for two transfers, mode 1 and DATA_W=8 -> second busy rises the cycle after the first irq; both words correct.
REQ-042 DATA_W=16, SEL_W=3, mode 2, data 0xBEEF loopback -> data_out=0xBEEF; 32 SCK edges; ss width 8.

Source files
------------

// File: rtl/spi_master_par.sv
// Parallel-load SPI master: one DATA_W-bit full-duplex transfer per start request,
// programmable SCK divider, all four SPI modes, selectable bit order and slave select.
module spi_master_par #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            clk_sel,
    input  logic [1:0]            mode,
    input  logic                  lsb_first,
    input  logic [SEL_W-1:0]      ss_sel,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  miso,
    output logic [DATA_W-1:0]     data_out,
    output logic                  sck,
    output logic                  mosi,
    output logic [(2**SEL_W)-1:0] ss,
    output logic                  busy,
    output logic                  irq
);

    localparam int unsigned NUM_SS = 2**SEL_W;
    localparam int unsigned EDGES  = 2 * DATA_W;
    localparam int unsigned ECW    = $clog2(EDGES + 1);
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ECW-1:0]      edge_cnt_q, edge_cnt_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [2:0]          clk_sel_q, clk_sel_d;
    logic [1:0]          mode_q, mode_d;
    logic                lsb_q, lsb_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [NUM_SS-1:0]   ss_q, ss_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;

    logic [CNT_W-1:0]    half_m1;
    logic                wrap;
    logic                start;
    logic                edge_now;
    logic [ECW-1:0]      edge_num;
    logic                lead;
    logic                do_sample;
    logic                do_shift;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        clk_sel_d  = clk_sel_q;
        mode_d     = mode_q;
        lsb_d      = lsb_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        busy_d     = busy_q;
        irq_d      = 1'b0;
        data_out_d = data_out_q;
        start      = 1'b0;
        edge_now   = 1'b0;
        edge_num   = '0;
        lead       = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;

        half_m1 = (CNT_W'(1) << clk_sel_q) - CNT_W'(1);
        wrap    = (cnt_q == half_m1);

        if (state_q inside {SETUP, XFER, HOLD}) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                sck_d  = mode_q[1];
                mosi_d = 1'b0;
                start  = en;
            end
            SETUP: begin
                if (wrap) begin
                    state_d  = XFER;
                    edge_now = 1'b1;
                    edge_num = ECW'(1);
                end
            end
            XFER: begin
                if (wrap) begin
                    if (edge_cnt_q == ECW'(EDGES)) begin
                        state_d = HOLD;
                    end else begin
                        edge_now = 1'b1;
                        edge_num = edge_cnt_q + ECW'(1);
                    end
                end
            end
            HOLD: begin
                if (wrap) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    irq_d      = 1'b1;
                    ss_d       = '1;
                    mosi_d     = 1'b0;
                    data_out_d = rx_q;
                end
            end
            DONE: begin
                // A request still held here chains straight into the next transfer.
                state_d = IDLE;
                sck_d   = mode_q[1];
                mosi_d  = 1'b0;
                start   = en;
            end
            default: state_d = IDLE;
        endcase

        // Odd edges lead; CPHA picks whether leading edges sample or shift.
        if (edge_now) begin
            sck_d      = ~sck_q;
            edge_cnt_d = edge_num;
            lead       = edge_num[0];
            do_sample  = (lead != mode_q[0]);
            do_shift   = mode_q[0] ? (lead && (edge_num != ECW'(1)))
                                   : (!lead && (edge_num != ECW'(EDGES)));
        end

        if (do_sample) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end

        if (do_shift) begin
            if (lsb_q) begin
                tx_d   = {1'b0, tx_q[DATA_W-1:1]};
                mosi_d = tx_q[1];
            end else begin
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                mosi_d = tx_q[DATA_W-2];
            end
        end

        if (start) begin
            state_d    = SETUP;
            cnt_d      = '0;
            edge_cnt_d = '0;
            tx_d       = data_in;
            rx_d       = '0;
            clk_sel_d  = clk_sel;
            mode_d     = mode;
            lsb_d      = lsb_first;
            sck_d      = mode[1];
            mosi_d     = lsb_first ? data_in[0] : data_in[DATA_W-1];
            ss_d       = ~(NUM_SS'(1) << ss_sel);
            busy_d     = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            clk_sel_q  <= '0;
            mode_q     <= '0;
            lsb_q      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_q       <= '1;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            clk_sel_q  <= clk_sel_d;
            mode_q     <= mode_d;
            lsb_q      <= lsb_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign ss       = ss_q;
    assign busy     = busy_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_spi_master_par.sv
// Self-checking bench for spi_master_par: vector table plus scoreboard, a behavioural
// SPI slave, and hand-written abort, ignored-request, chained and 16-bit sequences.
module tb_spi_master_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [2:0] clk_sel;
    logic [1:0] mode;
    logic       lsb_first;
    logic [1:0] ss_sel;
    logic [7:0] data_in;
    logic       miso;
    logic [7:0] data_out;
    logic       sck;
    logic       mosi;
    logic [3:0] ss;
    logic       busy;
    logic       irq;
    logic       loop;

    logic        b_en;
    logic [2:0]  b_clk_sel;
    logic [1:0]  b_mode;
    logic        b_lsb_first;
    logic [2:0]  b_ss_sel;
    logic [15:0] b_data_in;
    logic        b_miso;
    logic [15:0] b_data_out;
    logic        b_sck;
    logic        b_mosi;
    logic [7:0]  b_ss;
    logic        b_busy;
    logic        b_irq;

    // Slave model state
    logic [7:0] s_resp;
    logic [1:0] s_mode;
    logic       s_lsb;
    logic       sl_act  = 1'b0;
    logic       sl_prev = 1'b0;
    logic       miso_s  = 1'b0;
    logic [7:0] sl_rx   = 8'h00;
    int         sl_ti   = 0;
    int         sl_ri   = 0;

    assign miso   = loop ? mosi : miso_s;
    assign b_miso = b_mosi;

    spi_master_par #(.DATA_W(8), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .clk_sel(clk_sel), .mode(mode),
        .lsb_first(lsb_first), .ss_sel(ss_sel), .data_in(data_in), .miso(miso),
        .data_out(data_out), .sck(sck), .mosi(mosi), .ss(ss), .busy(busy), .irq(irq)
    );

    spi_master_par #(.DATA_W(16), .SEL_W(3)) dut16 (
        .clk(clk), .rst(rst), .en(b_en), .clk_sel(b_clk_sel), .mode(b_mode),
        .lsb_first(b_lsb_first), .ss_sel(b_ss_sel), .data_in(b_data_in), .miso(b_miso),
        .data_out(b_data_out), .sck(b_sck), .mosi(b_mosi), .ss(b_ss), .busy(b_busy),
        .irq(b_irq)
    );

    function automatic int ord(input int i, input logic l);
        return l ? i : 7 - i;
    endfunction

    // Behavioural slave: observes sck between clk edges, captures mosi, drives miso
    always @(negedge clk) begin
        if (&ss) begin
            sl_act <= 1'b0;
        end else if (!sl_act) begin
            sl_act  <= 1'b1;
            sl_prev <= sck;
            sl_rx   <= 8'h00;
            sl_ri   <= 0;
            if (!s_mode[0]) begin
                miso_s <= s_resp[ord(0, s_lsb)];
                sl_ti  <= 1;
            end else begin
                sl_ti  <= 0;
            end
        end else if (sck != sl_prev) begin
            sl_prev <= sck;
            if ((sck != s_mode[1]) == !s_mode[0]) begin
                if (sl_ri < 8) begin
                    sl_rx[ord(sl_ri, s_lsb)] <= mosi;
                    sl_ri <= sl_ri + 1;
                end
            end else if (sl_ti < 8) begin
                miso_s <= s_resp[ord(sl_ti, s_lsb)];
                sl_ti  <= sl_ti + 1;
            end
        end
    end

    typedef struct {
        logic [1:0] mode;
        logic       lsb;
        logic [2:0] cs;
        logic [1:0] sel;
        logic [7:0] data;
        logic [7:0] resp;
        logic       loop;
        logic [7:0] exp_out;
    } vec_t;

    typedef struct {
        logic [7:0] exp_out;
        logic [7:0] exp_cap;
        logic       chk_cap;
        logic [3:0] exp_ss;
        int         exp_busy;
        logic       cpol;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic sb_t mk_entry(input vec_t v);
        sb_t e;
        e.exp_out  = v.exp_out;
        e.exp_cap  = v.data;
        e.chk_cap  = !v.loop;
        e.exp_ss   = ~(4'd1 << v.sel);
        e.exp_busy = 18 << v.cs;
        e.cpol     = v.mode[1];
        return e;
    endfunction

    task automatic start_xfer(input vec_t v, input bit hold, input bit push);
        mode = v.mode; lsb_first = v.lsb; clk_sel = v.cs; ss_sel = v.sel;
        data_in = v.data; loop = v.loop;
        s_mode = v.mode; s_lsb = v.lsb; s_resp = v.resp;
        en = 1'b1;
        if (push) sb_q.push_back(mk_entry(v));
        @(negedge clk);
        check("busy_rise", 32'(busy), 32'd1);
        if (!hold) begin
            en        = 1'b0;
            data_in   = 8'($urandom);
            mode      = 2'($urandom);
            lsb_first = 1'($urandom);
            clk_sel   = 3'($urandom);
            ss_sel    = 2'($urandom);
        end
    endtask

    task automatic finish_xfer(input int pulse_at, input logic [7:0] pulse_data);
        sb_t  e;
        int   bcnt = 0;
        int   edges = 0;
        int   ss_bad = 0;
        bit   done = 0;
        logic psck;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e    = sb_q[0];
        psck = sck;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            if (irq) begin
                done = 1;
            end else begin
                if (busy) begin
                    bcnt++;
                    if (ss !== e.exp_ss) ss_bad++;
                    if (sck !== psck) edges++;
                end
                psck = sck;
                if (pulse_at != 0) begin
                    if (bcnt == pulse_at) begin
                        en = 1'b1;
                        data_in = pulse_data;
                    end else begin
                        en = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            check("irq_timeout", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.exp_out));
        check("busy_len", 32'(bcnt), 32'(e.exp_busy));
        check("sck_edges", 32'(edges), 32'd16);
        check("ss_during_xfer", 32'(ss_bad), 32'd0);
        check("ss_at_done", 32'(ss), 32'hF);
        if (e.chk_cap) check("slave_capture", 32'(sl_rx), 32'(e.exp_cap));
        @(negedge clk);
        check("irq_one_cycle", 32'(irq), 32'd0);
        if (!busy) begin
            check("idle_sck", 32'(sck), 32'(e.cpol));
            check("idle_mosi", 32'(mosi), 32'd0);
        end
    endtask

    task automatic quiet(input int n);
        int irqs = 0;
        int bz = 0;
        repeat (n) begin
            @(negedge clk);
            irqs += 32'(irq);
            bz   += 32'(busy);
        end
        check("no_extra_irq", 32'(irqs), 32'd0);
        check("no_extra_busy", 32'(bz), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t vb;
        int   ed;
        int   bcnt;
        int   edges;
        int   ss_bad;
        bit   done;
        logic psck;

        vecs[0] = '{2'd0, 1'b0, 3'd0, 2'd0, 8'hA5, 8'h00, 1'b1, 8'hA5};
        vecs[1] = '{2'd3, 1'b1, 3'd2, 2'd2, 8'h96, 8'h3C, 1'b0, 8'h3C};
        vecs[2] = '{2'd1, 1'b0, 3'd1, 2'd1, 8'hC3, 8'h81, 1'b0, 8'h81};
        vecs[3] = '{2'd2, 1'b1, 3'd0, 2'd3, 8'h01, 8'h80, 1'b0, 8'h80};
        vecs[4] = '{2'd0, 1'b1, 3'd3, 2'd1, 8'h7E, 8'hE7, 1'b0, 8'hE7};
        vecs[5] = '{2'd3, 1'b0, 3'd0, 2'd0, 8'hFF, 8'h00, 1'b0, 8'h00};

        rst = 1'b0; en = 1'b0; clk_sel = '0; mode = '0; lsb_first = 1'b0;
        ss_sel = '0; data_in = '0; loop = 1'b1;
        s_resp = '0; s_mode = '0; s_lsb = 1'b0;
        b_en = 1'b0; b_clk_sel = '0; b_mode = '0; b_lsb_first = 1'b0;
        b_ss_sel = '0; b_data_in = '0;

        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss", 32'(ss), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_ss16", 32'(b_ss), 32'hFF);

        // en presented together with reset release is taken on that first edge
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start_xfer(vecs[i], 1'b0, 1'b1);
            finish_xfer(0, 8'h00);
        end

        // Second request mid-transfer is dropped
        v = '{2'd1, 1'b0, 3'd1, 2'd1, 8'h3C, 8'h99, 1'b0, 8'h99};
        start_xfer(v, 1'b0, 1'b1);
        finish_xfer(10, 8'hFF);
        quiet(40);

        // Reset after the third leading edge aborts the transfer
        v = '{2'd0, 1'b0, 3'd0, 2'd0, 8'hC3, 8'h00, 1'b1, 8'hC3};
        start_xfer(v, 1'b0, 1'b0);
        ed = 0;
        psck = sck;
        for (int c = 0; c < 200 && ed < 5; c++) begin
            @(negedge clk);
            if (sck !== psck) ed++;
            psck = sck;
        end
        check("abort_reach_edge5", 32'(ed), 32'd5);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ss", 32'(ss), 32'hF);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        rst = 1'b1;
        quiet(10);
        v = '{2'd0, 1'b0, 3'd0, 2'd0, 8'h5A, 8'h00, 1'b1, 8'h5A};
        start_xfer(v, 1'b0, 1'b1);
        finish_xfer(0, 8'h00);

        // en held high: second transfer chains directly after the first DONE
        v  = '{2'd1, 1'b0, 3'd0, 2'd3, 8'h6D, 8'h00, 1'b1, 8'h6D};
        vb = '{2'd1, 1'b0, 3'd0, 2'd3, 8'hB2, 8'h00, 1'b1, 8'hB2};
        start_xfer(v, 1'b1, 1'b1);
        data_in = vb.data;
        sb_q.push_back(mk_entry(vb));
        finish_xfer(0, 8'h00);
        check("chain_busy_after_irq", 32'(busy), 32'd1);
        en = 1'b0;
        finish_xfer(0, 8'h00);

        // 16-bit instance, mode 2, loopback
        b_mode = 2'd2; b_clk_sel = 3'd1; b_ss_sel = 3'd5; b_lsb_first = 1'b0;
        b_data_in = 16'hBEEF; b_en = 1'b1;
        @(negedge clk);
        b_en = 1'b0; b_data_in = 16'h1234; b_mode = 2'd0;
        bcnt = 0; edges = 0; ss_bad = 0; done = 0;
        psck = b_sck;
        for (int c = 0; c < 1000 && !done; c++) begin
            if (b_irq) begin
                done = 1;
            end else begin
                if (b_busy) begin
                    bcnt++;
                    if (b_ss !== 8'hDF) ss_bad++;
                    if (b_sck !== psck) edges++;
                end
                psck = b_sck;
                @(negedge clk);
            end
        end
        check("w16_done", 32'(done), 32'd1);
        check("w16_data_out", 32'(b_data_out), 32'hBEEF);
        check("w16_edges", 32'(edges), 32'd32);
        check("w16_busy_len", 32'(bcnt), 32'd68);
        check("w16_ss", 32'(ss_bad), 32'd0);
        @(negedge clk);
        check("w16_idle_sck", 32'(b_sck), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
